// File: rtl/mmcm_clk_src_ctrl.sv
// Reference-clock supervisor for the PTP peripheral MMCM: qualifies both 200 MHz inputs
// from their divided toggles, picks CLKINSEL and sequences the MMCM reset around LOCKED.
module mmcm_clk_src_ctrl #(
  parameter int unsigned WINDOW_CYCLES       = 1024,
  parameter int unsigned MIN_EDGES           = 60,
  parameter int unsigned MAX_EDGES           = 68,
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk1_div_tgl,
  input  logic       clk2_div_tgl,
  input  logic       force_en,
  input  logic       force_sel,
  input  logic       mmcm_locked,
  output logic       clk_in_sel,
  output logic       mmcm_resetn,
  output logic       clk_ok,
  output logic       src1_valid,
  output logic       src2_valid,
  output logic [7:0] switch_cnt
);

  localparam int unsigned WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned TMR_W  = $clog2(LOCK_TIMEOUT_CYCLES + RST_HOLD_CYCLES) + 1;
  localparam int unsigned EDGE_W = 16;
  localparam int unsigned SW_W   = 8;

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0]  HOLD_LAST = TMR_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCK_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [EDGE_W-1:0] EDGE_LO   = EDGE_W'(MIN_EDGES);
  localparam logic [EDGE_W-1:0] EDGE_HI   = EDGE_W'(MAX_EDGES);
  localparam logic [EDGE_W-1:0] EDGE_SAT  = '1;
  localparam logic [SW_W-1:0]   SW_SAT    = '1;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_SWITCH    = 2'd3
  } state_e;

  // Index 0 is clk_in1, index 1 is clk_in2. Bits [1:0] synchronise, bit 2 is the previous sample.
  logic [1:0][2:0]        tgl_q;
  logic [1:0]             lock_q;
  logic                   locked_sync;
  logic [1:0]             src_edge;
  logic [1:0]             win_good;

  logic [WIN_W-1:0]       win_q, win_d;
  logic                   wrap;
  logic [1:0][EDGE_W-1:0] ecnt_q, ecnt_d;
  logic [1:0]             good_q, good_d;
  logic [1:0]             valid_q, valid_d;

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   sel_q, sel_d;
  logic [SW_W-1:0]        swcnt_q, swcnt_d;
  logic                   resetn_q, resetn_d;
  logic                   clk_ok_q, clk_ok_d;
  logic                   target;
  logic                   sel_valid;

  assign locked_sync = lock_q[1];
  assign wrap        = (win_q == WIN_LAST);

  // Synchronisers and activity measurement registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgl_q   <= '0;
      lock_q  <= '0;
      win_q   <= '0;
      ecnt_q  <= '0;
      good_q  <= '0;
      valid_q <= '0;
    end else begin
      tgl_q[0] <= {tgl_q[0][1:0], clk1_div_tgl};
      tgl_q[1] <= {tgl_q[1][1:0], clk2_div_tgl};
      lock_q   <= {lock_q[0], mmcm_locked};
      win_q    <= win_d;
      ecnt_q   <= ecnt_d;
      good_q   <= good_d;
      valid_q  <= valid_d;
    end
  end

  // Window counter, per-source edge counting and two-good / one-bad qualification.
  always_comb begin
    win_d    = wrap ? '0 : win_q + WIN_W'(1);
    ecnt_d   = ecnt_q;
    good_d   = good_q;
    valid_d  = valid_q;
    src_edge = '0;
    win_good = '0;
    for (int i = 0; i < 2; i++) begin
      src_edge[i] = tgl_q[i][2] ^ tgl_q[i][1];
      win_good[i] = (ecnt_q[i] >= EDGE_LO) && (ecnt_q[i] <= EDGE_HI);
      if (wrap) begin
        ecnt_d[i]  = src_edge[i] ? EDGE_W'(1) : EDGE_W'(0);
        good_d[i]  = win_good[i];
        valid_d[i] = win_good[i] & good_q[i];
      end else if (src_edge[i] && (ecnt_q[i] != EDGE_SAT)) begin
        ecnt_d[i] = ecnt_q[i] + EDGE_W'(1);
      end
    end
  end

  // Force wins over validity; with nothing qualified the selection stays put.
  always_comb begin
    if (force_en)        target = force_sel;
    else if (valid_q[0]) target = 1'b1;
    else if (valid_q[1]) target = 1'b0;
    else                 target = sel_q;
    sel_valid = sel_q ? valid_q[0] : valid_q[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_HOLD;
      tmr_q    <= '0;
      sel_q    <= 1'b1;
      swcnt_q  <= '0;
      resetn_q <= 1'b0;
      clk_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      sel_q    <= sel_d;
      swcnt_q  <= swcnt_d;
      resetn_q <= resetn_d;
      clk_ok_q <= clk_ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sel_d   = sel_q;
    swcnt_d = swcnt_q;
    case (state_q)
      ST_HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_sync) begin
          state_d = ST_RUN;
          tmr_d   = '0;
        end else if (tmr_q == LOCK_LAST) begin
          state_d = ST_SWITCH;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_sync || (target != sel_q)) state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        sel_d = target;
        if ((target != sel_q) && (swcnt_q != SW_SAT)) swcnt_d = swcnt_q + SW_W'(1);
        state_d = ST_HOLD;
        tmr_d   = '0;
      end
      default: state_d = ST_HOLD;
    endcase
    // Registered from the next state so the MMCM is in reset exactly during SWITCH and HOLD.
    resetn_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_RUN);
    clk_ok_d = (state_d == ST_RUN) && locked_sync && sel_valid;
  end

  assign clk_in_sel  = sel_q;
  assign mmcm_resetn = resetn_q;
  assign clk_ok      = clk_ok_q;
  assign src1_valid  = valid_q[0];
  assign src2_valid  = valid_q[1];
  assign switch_cnt  = swcnt_q;

endmodule

// File: tb/tb_mmcm_clk_src_ctrl.sv
// Bench for mmcm_clk_src_ctrl: a behavioural MMCM lock model, asynchronous toggle generators,
// and a queue of expected reset pulses checked at every mmcm_resetn rise.
`timescale 1ns/1ps
module tb_mmcm_clk_src_ctrl;

  localparam int unsigned LT = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk1_div_tgl = 1'b0;
  logic       clk2_div_tgl = 1'b0;
  logic       force_en = 1'b0;
  logic       force_sel = 1'b0;
  logic       mmcm_locked = 1'b0;
  logic       clk_in_sel;
  logic       mmcm_resetn;
  logic       clk_ok;
  logic       src1_valid;
  logic       src2_valid;
  logic [7:0] switch_cnt;

  int total = 0;
  int bad = 0;
  int t1_ns = 320;
  int t2_ns = 320;
  logic lock_en = 1'b0;
  logic lock_drop = 1'b0;
  int lk_cnt = 0;
  int exp_cnt = 0;

  typedef struct {
    logic       sel;
    logic [7:0] cnt;
    int         len;
  } pulse_t;
  pulse_t exp_q[$];

  mmcm_clk_src_ctrl #(
    .WINDOW_CYCLES(1024), .MIN_EDGES(60), .MAX_EDGES(68),
    .RST_HOLD_CYCLES(16), .LOCK_TIMEOUT_CYCLES(LT)
  ) dut (
    .clk(clk), .rst(rst), .clk1_div_tgl(clk1_div_tgl), .clk2_div_tgl(clk2_div_tgl),
    .force_en(force_en), .force_sel(force_sel), .mmcm_locked(mmcm_locked),
    .clk_in_sel(clk_in_sel), .mmcm_resetn(mmcm_resetn), .clk_ok(clk_ok),
    .src1_valid(src1_valid), .src2_valid(src2_valid), .switch_cnt(switch_cnt)
  );

  always #10 clk = ~clk;

  // Divided reference clocks; half period in ns, 0 stops the toggle.
  initial begin
    #7;
    forever begin
      if (t1_ns == 0) #20;
      else begin #(t1_ns); clk1_div_tgl = ~clk1_div_tgl; end
    end
  end
  initial begin
    #7;
    forever begin
      if (t2_ns == 0) #20;
      else begin #(t2_ns); clk2_div_tgl = ~clk2_div_tgl; end
    end
  end

  // MMCM model: LOCKED rises 100 cycles after resetn is released.
  always @(posedge clk) begin
    #1;
    if (!mmcm_resetn || !lock_en || lock_drop) begin
      lk_cnt = 0;
      mmcm_locked = 1'b0;
    end else if (lk_cnt < 100) begin
      lk_cnt++;
    end else begin
      mmcm_locked = 1'b1;
    end
  end

  // Every reset pulse must match the next expected record.
  int   low_cnt = 0;
  logic was_low = 1'b0;
  always @(negedge clk) begin
    pulse_t e;
    if (rst) begin
      low_cnt = 0;
      was_low = 1'b0;
    end else if (!mmcm_resetn) begin
      low_cnt++;
      was_low = 1'b1;
    end else if (was_low) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL pulse_unexpected: got pulse sel=%0d cnt=%0d len=%0d, required none",
                 clk_in_sel, switch_cnt, low_cnt);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (clk_in_sel !== e.sel) begin
          bad++; $display("FAIL pulse_sel: got %0d, required %0d", clk_in_sel, e.sel);
        end
        total++;
        if (switch_cnt !== e.cnt) begin
          bad++; $display("FAIL pulse_cnt: got %0d, required %0d", switch_cnt, e.cnt);
        end
        total++;
        if (low_cnt != e.len) begin
          bad++; $display("FAIL pulse_len: got %0d, required %0d", low_cnt, e.len);
        end
      end
      was_low = 1'b0;
      low_cnt = 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic sel, input int cnt, input int len);
    pulse_t p;
    p.sel = sel;
    p.cnt = 8'(cnt);
    p.len = len;
    exp_q.push_back(p);
  endtask

  task automatic test_reset;
    rst = 1'b1; force_en = 1'b0; lock_en = 1'b1; t1_ns = 320; t2_ns = 320;
    tick(5);
    total++; if (clk_in_sel !== 1'b1) begin bad++; $display("FAIL rst_sel: got %0d, required 1", clk_in_sel); end
    total++; if (mmcm_resetn !== 1'b0) begin bad++; $display("FAIL rst_resetn: got %0d, required 0", mmcm_resetn); end
    total++; if (clk_ok !== 1'b0) begin bad++; $display("FAIL rst_clk_ok: got %0d, required 0", clk_ok); end
    total++; if (src1_valid !== 1'b0) begin bad++; $display("FAIL rst_v1: got %0d, required 0", src1_valid); end
    total++; if (src2_valid !== 1'b0) begin bad++; $display("FAIL rst_v2: got %0d, required 0", src2_valid); end
    total++; if (switch_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt: got %0d, required 0", switch_cnt); end
    exp_cnt = 0;
    push_exp(1'b1, 0, 16);
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    int n;
    tick(1500);
    total++; if (src1_valid !== 1'b0) begin bad++; $display("FAIL nom_one_window_v1: got %0d, required 0", src1_valid); end
    total++; if (clk_ok !== 1'b0) begin bad++; $display("FAIL nom_unqualified_ok: got %0d, required 0", clk_ok); end
    total++; if (mmcm_resetn !== 1'b1) begin bad++; $display("FAIL nom_resetn: got %0d, required 1", mmcm_resetn); end
    n = 0;
    while (!(src1_valid && src2_valid) && n < 1000) begin tick(1); n++; end
    total++; if (n >= 1000) begin bad++; $display("FAIL nom_valid_wait: timed out v1=%0d v2=%0d, required both 1", src1_valid, src2_valid); end
    tick(3);
    total++; if (clk_ok !== 1'b1) begin bad++; $display("FAIL nom_clk_ok: got %0d, required 1", clk_ok); end
    total++; if (clk_in_sel !== 1'b1) begin bad++; $display("FAIL nom_sel: got %0d, required 1", clk_in_sel); end
    total++; if (switch_cnt !== 8'd0) begin bad++; $display("FAIL nom_cnt: got %0d, required 0", switch_cnt); end
  endtask

  task automatic test_src_loss;
    int n;
    t1_ns = 0;
    exp_cnt = 1;
    push_exp(1'b0, exp_cnt, 17);
    n = 0;
    while (src1_valid && n < 2200) begin tick(1); n++; end
    total++; if (n >= 2200) begin bad++; $display("FAIL loss_v1_wait: got v1=%0d, required 0", src1_valid); end
    total++; if (src2_valid !== 1'b1) begin bad++; $display("FAIL loss_v2: got %0d, required 1", src2_valid); end
    n = 0;
    while (!(clk_ok && clk_in_sel == 1'b0) && n < 400) begin tick(1); n++; end
    total++; if (n >= 400) begin bad++; $display("FAIL loss_relock: got ok=%0d sel=%0d, required ok=1 sel=0", clk_ok, clk_in_sel); end
    total++; if (switch_cnt !== 8'd1) begin bad++; $display("FAIL loss_cnt: got %0d, required 1", switch_cnt); end
  endtask

  task automatic test_revert;
    int n;
    t1_ns = 320;
    exp_cnt = 2;
    push_exp(1'b1, exp_cnt, 17);
    n = 0;
    while (!src1_valid && n < 3300) begin tick(1); n++; end
    total++; if (n >= 3300) begin bad++; $display("FAIL revert_v1_wait: got v1=%0d, required 1", src1_valid); end
    n = 0;
    while (!(clk_ok && clk_in_sel == 1'b1) && n < 400) begin tick(1); n++; end
    total++; if (n >= 400) begin bad++; $display("FAIL revert_relock: got ok=%0d sel=%0d, required ok=1 sel=1", clk_ok, clk_in_sel); end
    total++; if (switch_cnt !== 8'd2) begin bad++; $display("FAIL revert_cnt: got %0d, required 2", switch_cnt); end
  endtask

  task automatic test_lock_loss;
    int n;
    lock_drop = 1'b1;
    push_exp(1'b1, exp_cnt, 17);
    tick(6);
    total++; if (clk_ok !== 1'b0) begin bad++; $display("FAIL lockloss_ok: got %0d, required 0", clk_ok); end
    lock_drop = 1'b0;
    n = 0;
    while (!clk_ok && n < 400) begin tick(1); n++; end
    total++; if (n >= 400) begin bad++; $display("FAIL lockloss_relock: got ok=%0d, required 1", clk_ok); end
    total++; if (switch_cnt !== 8'd2) begin bad++; $display("FAIL lockloss_cnt: got %0d, required 2", switch_cnt); end
  endtask

  task automatic test_bad_rates;
    int n;
    force_en = 1'b1; force_sel = 1'b1;
    t1_ns = 284; t2_ns = 353;
    n = 0;
    while ((src1_valid || src2_valid) && n < 3300) begin tick(1); n++; end
    total++; if (n >= 3300) begin bad++; $display("FAIL bad_wait: got v1=%0d v2=%0d, required both 0", src1_valid, src2_valid); end
    force_en = 1'b0;
    tick(1100);
    total++; if (clk_in_sel !== 1'b1) begin bad++; $display("FAIL bad_sel: got %0d, required 1", clk_in_sel); end
    total++; if (clk_ok !== 1'b0) begin bad++; $display("FAIL bad_clk_ok: got %0d, required 0", clk_ok); end
    total++; if (src2_valid !== 1'b0) begin bad++; $display("FAIL bad_v2: got %0d, required 0", src2_valid); end
    total++; if (switch_cnt !== 8'd2) begin bad++; $display("FAIL bad_cnt: got %0d, required 2", switch_cnt); end
  endtask

  task automatic test_lock_timeout;
    int n;
    lock_en = 1'b0;
    push_exp(1'b1, exp_cnt, 17);
    n = 0;
    while (mmcm_resetn && n < 20) begin tick(1); n++; end
    while (!mmcm_resetn && n < 60) begin tick(1); n++; end
    total++; if (n >= 60) begin bad++; $display("FAIL tmo_first_pulse: got resetn=%0d, required pulse", mmcm_resetn); end
    push_exp(1'b1, exp_cnt, 17);
    n = 0;
    while (mmcm_resetn && n < 5000) begin tick(1); n++; end
    while (!mmcm_resetn && n < 5000) begin tick(1); n++; end
    total++; if (n != int'(LT) + 17) begin bad++; $display("FAIL tmo_period: got %0d, required %0d", n, LT + 17); end
    total++; if (switch_cnt !== 8'd2) begin bad++; $display("FAIL tmo_cnt: got %0d, required 2", switch_cnt); end
  endtask

  task automatic test_force;
    int n;
    logic timed_out;
    lock_en = 1'b1; force_en = 1'b1; force_sel = 1'b0;
    exp_cnt = 3;
    push_exp(1'b0, exp_cnt, 17);
    n = 0;
    while (!(clk_in_sel == 1'b0 && mmcm_locked) && n < 600) begin tick(1); n++; end
    total++; if (n >= 600) begin bad++; $display("FAIL force_wait: got sel=%0d locked=%0d, required sel=0 locked=1", clk_in_sel, mmcm_locked); end
    tick(4);
    total++; if (switch_cnt !== 8'd3) begin bad++; $display("FAIL force_cnt: got %0d, required 3", switch_cnt); end
    total++; if (clk_ok !== 1'b0) begin bad++; $display("FAIL force_ok: got %0d, required 0", clk_ok); end
    timed_out = 1'b0;
    for (int k = 0; k < 260 && !timed_out; k++) begin
      force_sel = ~force_sel;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      push_exp(force_sel, exp_cnt, 17);
      n = 0;
      while (!(clk_in_sel == force_sel && mmcm_locked) && n < 400) begin tick(1); n++; end
      if (n >= 400) timed_out = 1'b1;
      tick(4);
    end
    total++; if (timed_out) begin bad++; $display("FAIL toggle_wait: got sel=%0d, required %0d", clk_in_sel, force_sel); end
    total++; if (switch_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt: got %0d, required 255", switch_cnt); end
  endtask

  task automatic test_rst_mid;
    int n;
    lock_en = 1'b0;
    push_exp(force_sel, 255, 17);
    n = 0;
    while (mmcm_resetn && n < 20) begin tick(1); n++; end
    while (!mmcm_resetn && n < 60) begin tick(1); n++; end
    total++; if (n >= 60) begin bad++; $display("FAIL mid_pulse: got resetn=%0d, required pulse", mmcm_resetn); end
    tick(50);
    rst = 1'b1;
    #1;
    total++; if (clk_in_sel !== 1'b1) begin bad++; $display("FAIL mid_sel: got %0d, required 1", clk_in_sel); end
    total++; if (mmcm_resetn !== 1'b0) begin bad++; $display("FAIL mid_resetn: got %0d, required 0", mmcm_resetn); end
    total++; if (switch_cnt !== 8'd0) begin bad++; $display("FAIL mid_cnt: got %0d, required 0", switch_cnt); end
    total++; if (clk_ok !== 1'b0 || src1_valid !== 1'b0 || src2_valid !== 1'b0) begin
      bad++; $display("FAIL mid_flags: got ok=%0d v1=%0d v2=%0d, required all 0", clk_ok, src1_valid, src2_valid);
    end
    force_en = 1'b0; lock_en = 1'b1;
    tick(3);
    push_exp(1'b1, 0, 16);
    rst = 1'b0;
    n = 0;
    while (!mmcm_resetn && n < 40) begin tick(1); n++; end
    total++; if (n >= 40) begin bad++; $display("FAIL mid_restart: got resetn=%0d, required 1", mmcm_resetn); end
    tick(5);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending pulses, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_src_loss();
    test_revert();
    test_lock_loss();
    test_bad_rates();
    test_lock_timeout();
    test_force();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmcm_clk_src_ctrl.md
Name: mmcm_clk_src_ctrl

Overview:
- Supervises the two 200 MHz reference inputs of the PTP peripheral MMCM, which produces 50 MHz and 200 MHz outputs.
- Runs on an independent free-running 50 MHz oscillator.
- Measures the activity of each input clock through divided toggle signals, chooses the MMCM input, drives the MMCM active-low reset and watches LOCKED.
- Sits directly upstream of the MMCM: drives its clk_in_sel and resetn, and consumes its locked output.

Parameters:
- WINDOW_CYCLES, 1024: measurement window length in clk cycles.
- MIN_EDGES, 60: minimum toggle edges per window for a good window.
- MAX_EDGES, 68: maximum toggle edges per window for a good window.
- RST_HOLD_CYCLES, 16: clk cycles that mmcm_resetn is held low per reset pulse.
- LOCK_TIMEOUT_CYCLES, 65536: clk cycles allowed for lock before a retry or switch.

Ports:
- clk  in  1  free-running 50 MHz control clock
- rst  in  1  reset; asynchronous, active-high
- clk1_div_tgl  in  1  toggles every 64 clk_in1 cycles; asynchronous to clk
- clk2_div_tgl  in  1  toggles every 64 clk_in2 cycles; asynchronous to clk
- force_en  in  1  manual source override enable (quasi-static)
- force_sel  in  1  manual selection: 1 = clk_in1, 0 = clk_in2
- mmcm_locked  in  1  MMCM LOCKED; asynchronous to clk
- clk_in_sel  out  1  MMCM CLKINSEL: 1 = clk_in1, 0 = clk_in2
- mmcm_resetn  out  1  MMCM reset, active-low
- clk_ok  out  1  MMCM locked on a valid source
- src1_valid  out  1  clk_in1 qualified
- src2_valid  out  1  clk_in2 qualified
- switch_cnt  out  8  number of source changes, saturating

Behaviour:
- Reset values: clk_in_sel=1, mmcm_resetn=0, clk_ok=0, src1_valid=0, src2_valid=0, switch_cnt=0. State HOLD, all counters 0.
- Synchronisers: each tgl input and mmcm_locked pass through a 2-FF synchroniser. Edge detect is an XOR of synchronised bit n and bit n-1; rising and falling edges both count.
- Window counter: counts 0..WINDOW_CYCLES-1, then wraps.
- Per-source edge counters: 16-bit, saturating at 0xFFFF. On the wrap cycle each count is compared against MIN_EDGES..MAX_EDGES (inclusive) and the counter restarts at 0, or at 1 if an edge occurs on the wrap cycle.
- Validity: srcN_valid sets after 2 consecutive good windows and clears after 1 bad window. Flags update one cycle after the wrap.
- Target selection: target = force_sel if force_en; else 1 if src1_valid; else 0 if src2_valid; else the current clk_in_sel.
- FSM HOLD: mmcm_resetn=0, clk_ok=0. Counts RST_HOLD_CYCLES, then goes to WAIT_LOCK.
- FSM WAIT_LOCK: mmcm_resetn=1.
  - Synchronised locked=1: go to RUN.
  - Timeout counter reaches LOCK_TIMEOUT_CYCLES-1: go to SWITCH.
- FSM RUN: clk_ok = locked_sync & (valid flag of the selected source).
  - Locked_sync falls: go to SWITCH.
  - target != clk_in_sel: go to SWITCH. This covers primary auto-revert, loss of the selected source with the other valid, and force changes.
- FSM SWITCH (1 cycle):
  - clk_in_sel <= target.
  - switch_cnt increments, saturating at 255, only if target differs from the old selection.
  - mmcm_resetn is driven 0 in this cycle, then the FSM goes to HOLD.
  - clk_in_sel therefore only changes while the MMCM is held in reset.
- Both sources invalid: the selection does not move. A lock timeout still retries the reset on the same source indefinitely, and clk_ok stays 0.
- Simultaneous events: a locked fall and a target change in the same cycle produce a single SWITCH. Force takes precedence over validity.
- rst assertion mid-operation immediately restores all reset values. The sequence restarts in HOLD.

Test Plan:
- Both tgl inputs at nominal rate (64 edges/window), locked asserted 100 cycles after mmcm_resetn rises -> src1_valid=1 and src2_valid=1 after window 2; clk_in_sel=1; mmcm_resetn low for 16 cycles; clk_ok=1; switch_cnt=0.
- clk1_div_tgl stops while in RUN -> src1_valid=0 at the end of the next window; one cycle of SWITCH; clk_in_sel=0; 16-cycle reset pulse; relock gives clk_ok=1; switch_cnt=1.
- clk1 restored -> after 2 good windows src1_valid=1, auto-revert to clk_in_sel=1, switch_cnt=2.
- clk1 at 72 edges/window and clk2 at 58 edges/window -> both invalid; clk_in_sel stays 1; clk_ok=0.
- mmcm_locked never asserts -> reset pulse repeats every 65536+16+1 cycles on the same source with switch_cnt unchanged. force_en=1 with force_sel=0 -> switch to clk_in2 and switch_cnt +1.
- rst pulsed mid-WAIT_LOCK, and switch_cnt driven past 255 through repeated forced toggles -> all outputs return to reset values immediately; switch_cnt holds at 255.
